// File: rtl/rx_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rx_pkg : shared state encoding and default sizing for the UART receiver  |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package rx_pkg;

  localparam int unsigned DEF_CLK_DIV   = 434;
  localparam int unsigned DEF_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/rx_control_module_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rx_control_module_if : start-edge, serial line and received-byte bundle  |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
interface rx_control_module_if
  import rx_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
);
  logic                 h2l_sig;
  logic                 rx_pin;
  logic                 rx_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    output h2l_sig, rx_pin, rx_en,
    input  rx_data, rx_done, frame_err, rx_busy
  );

  modport slave (
    input  h2l_sig, rx_pin, rx_en,
    output rx_data, rx_done, frame_err, rx_busy
  );
endinterface
`default_nettype wire

// File: rtl/rx_bps_module.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rx_bps_module : per-bit baud counter with mid-bit and end-of-bit ticks   |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module rx_bps_module
  import rx_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  output logic mid_tick,
  output logic end_tick
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int HALF  = CLK_DIV / 2;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!count_en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mid_tick = (cnt_q == CNT_W'(HALF));
  assign end_tick = (cnt_q == CNT_W'(CLK_DIV - 1));

endmodule
`default_nettype wire

// File: rtl/rx_control_module.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rx_control_module : UART frame sequencer, mid-bit sampling, LSB first    |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module rx_control_module
  import rx_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  rx_control_module_if.slave   bus
);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  rx_state_e            state_q, state_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_busy_q, rx_busy_d;
  logic                 mid_tick;
  logic                 end_tick;

  rx_bps_module #(
    .CLK_DIV (CLK_DIV)
  ) u_bps (
    .clk      (clk),
    .rst      (rst),
    .count_en (state_q != ST_IDLE),
    .mid_tick (mid_tick),
    .end_tick (end_tick)
  );

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.h2l_sig && bus.rx_en) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        // A line back high at mid start bit was a glitch, not a frame.
        if (mid_tick && bus.rx_pin) begin
          state_d = ST_IDLE;
        end else if (end_tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (mid_tick) begin
          shift_d[bit_idx_q] = bus.rx_pin;
        end
        if (end_tick) begin
          if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (mid_tick) begin
          if (bus.rx_pin) begin
            state_d   = ST_DONE;
            rx_data_d = shift_q;
            rx_done_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rx_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = rx_busy_q;

endmodule
`default_nettype wire
